// File: rtl/bip_dbg_pkg.sv
// Shared definitions for the BIP debug sequencer: state encoding, command
// bytes, frame geometry and the report-frame byte selector.
// Latency: n/a (declarations only). Backpressure: n/a.
package bip_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_SEND    = 2'd2,
    ST_WAIT_TX = 2'd3
  } state_t;

  localparam logic [7:0]  CMD_START_DEF = 8'h53;
  localparam logic [7:0]  CMD_STEP_DEF  = 8'h54;
  localparam int          FRAME_BYTES   = 6;
  localparam logic [2:0]  LAST_IDX      = 3'(FRAME_BYTES - 1);
  localparam logic [15:0] CNT_MAX       = 16'hFFFF;

  // Report frame, MSB first: count, pc snapshot, acc snapshot.
  function automatic logic [7:0] frame_byte(input logic [15:0] cnt,
                                            input logic [15:0] pc_s,
                                            input logic [15:0] acc_s,
                                            input logic [2:0]  idx);
    case (idx)
      3'd0:    frame_byte = cnt[15:8];
      3'd1:    frame_byte = cnt[7:0];
      3'd2:    frame_byte = pc_s[15:8];
      3'd3:    frame_byte = pc_s[7:0];
      3'd4:    frame_byte = acc_s[15:8];
      3'd5:    frame_byte = acc_s[7:0];
      default: frame_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/bip_debug_unit.sv
// Debug sequencer: start BIP on a UART command, count cycles to halt, report a 6-byte frame.
// Latency: start_bip one cycle after rx_done; first tx_start one cycle after halt is sampled.
// Backpressure: one byte in flight; next byte only after tx_done, rx bytes dropped while busy.
//
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   rx_done, rx_data      - received-byte strobe and byte from the UART receiver
//   tx_start, tx_data     - transmit strobe and byte to the UART transmitter
//   tx_done               - transmitter finished the current byte
//   halt, pc, acc         - processor halt flag, program counter and accumulator
//   start_bip             - processor enable
//   busy, led             - not-idle flag; sticky "has halted" indicator
//
// Optional: define BIP_DBG_STEP_EN to add the single-step command (CMD_STEP).
module bip_debug_unit
  import bip_dbg_pkg::*;
#(
  parameter int         AB        = 11,
  parameter int         DB        = 16,
  parameter logic [7:0] CMD_START = CMD_START_DEF,
  parameter logic [7:0] CMD_STEP  = CMD_STEP_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_done,
  input  logic [7:0]    rx_data,
  input  logic          tx_done,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          halt,
  input  logic [AB-1:0] pc,
  input  logic [DB-1:0] acc,
  output logic          start_bip,
  output logic          busy,
  output logic          led
);

  // Elaboration-time parameter sanity checks.
  if (AB < 1 || AB > 16) begin : g_bad_ab
    $error("bip_debug_unit: AB must be in 1..16");
  end
  if (DB != 16) begin : g_bad_db
    $error("bip_debug_unit: DB must be 16 for the report frame");
  end
  if (CMD_STEP == CMD_START) begin : g_bad_cmd
    $error("bip_debug_unit: CMD_STEP must differ from CMD_START");
  end

  state_t      state_q, state_d;
  logic [15:0] count_q;
  logic [15:0] pc_snap_q;
  logic [15:0] acc_snap_q;
  logic [2:0]  idx_q;
  logic        start_bip_q;
  logic        led_q;
  logic        cmd_start_hit;
  logic        cmd_step_hit;
  logic        snap_now;
  logic [7:0]  cur_byte;

  assign cmd_start_hit = rx_done && (rx_data == CMD_START);

`ifdef BIP_DBG_STEP_EN
  logic step_q;

  assign cmd_step_hit = rx_done && (rx_data == CMD_STEP);
  // A step run snapshots in the RUN cycle right after its single enable
  // cycle, so the processor state reflects the one executed step.
  assign snap_now = (state_q == ST_RUN) && (step_q ? !start_bip_q : halt);
`else
  assign cmd_step_hit = 1'b0;
  assign snap_now     = (state_q == ST_RUN) && halt;
`endif

  assign cur_byte = frame_byte(count_q, pc_snap_q, acc_snap_q, idx_q);

  // Next state and transmit-side outputs.
  always_comb begin
    state_d  = state_q;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (cmd_start_hit || cmd_step_hit) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (snap_now) state_d = ST_SEND;
      end
      ST_SEND: begin
        tx_start = 1'b1;
        tx_data  = cur_byte;
        state_d  = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        // Byte stays on tx_data until the transmitter reports completion.
        tx_data = cur_byte;
        if (tx_done) state_d = (idx_q == LAST_IDX) ? ST_IDLE : ST_SEND;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= 16'h0000;
      pc_snap_q   <= 16'h0000;
      acc_snap_q  <= 16'h0000;
      idx_q       <= 3'd0;
      start_bip_q <= 1'b0;
      led_q       <= 1'b0;
`ifdef BIP_DBG_STEP_EN
      step_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;

      if (state_q == ST_IDLE) begin
        if (cmd_start_hit || cmd_step_hit) begin
          count_q     <= 16'h0000;
          start_bip_q <= 1'b1;
        end
`ifdef BIP_DBG_STEP_EN
        step_q <= cmd_step_hit;
`endif
      end

      if (state_q == ST_RUN) begin
        // Every enabled cycle is counted, including the one that halts.
        if (start_bip_q && (count_q != CNT_MAX)) count_q <= count_q + 16'd1;
        if (halt) led_q <= 1'b1;
`ifdef BIP_DBG_STEP_EN
        if (step_q) start_bip_q <= 1'b0;
`endif
        if (snap_now) begin
          pc_snap_q   <= 16'(pc);
          acc_snap_q  <= 16'(acc);
          idx_q       <= 3'd0;
          start_bip_q <= 1'b0;
        end
      end

      if ((state_q == ST_WAIT_TX) && tx_done && (idx_q != LAST_IDX))
        idx_q <= idx_q + 3'd1;
    end
  end

  assign start_bip = start_bip_q;
  assign led       = led_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
